sm4_key_sched: RTL

- Sequences SM4 key expansion. Accepts a 128-bit master key over a valid/ready handshake and computes one round key per cycle for 32 rounds.
- Stores the 32 round keys in an internal register file. A 1-cycle-latency read port serves them to the SM4 round datapath: ascending address for encryption, descending for decryption.
- Replaces free-running combinational key rounds with a controlled, restartable scheduler.

---
 rtl/sm4_pkg.sv | 32 +++
 rtl/sbox_32b.sv | 39 +++
 rtl/sm4_key_round.sv | 29 ++
 rtl/sm4_key_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared constants and types for the SM4 key expansion slice.
package sm4_pkg;

   // Default number of round keys produced by one SM4 key expansion.
   localparam int SM4_ROUNDS = 32;

   // System parameter FK, XORed into the master key words before round 0.
   localparam logic [31:0] FK0 = 32'hA3B1BAC6;
   localparam logic [31:0] FK1 = 32'h56AA3350;
   localparam logic [31:0] FK2 = 32'h677D9197;
   localparam logic [31:0] FK3 = 32'hB27022DC;

   // Round constants CK[i]: byte j of entry i is (4i+j)*7 mod 256.
   localparam logic [31:0] CK_TBL [SM4_ROUNDS] = '{
      32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
      32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
      32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
      32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
      32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
      32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
      32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
      32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
   };

   // Scheduler states: waiting for a key, generating keys, keys ready.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } sched_state_t;

endpackage

// File: rtl/sbox_32b.sv
// Four parallel SM4 S-box lookups, one per byte of a 32-bit word.
module sbox_32b (
   input  logic [31:0] din,
   output logic [31:0] dout
);

   // S-box table, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      logic [10:0] bit_pos;
      bit_pos  = 11'd2047 - {b, 3'b000};
      sub_byte = SBOX_TBL[bit_pos -: 8];
   endfunction

   // Substitute every byte independently.
   always_comb begin
      dout = {sub_byte(din[31:24]), sub_byte(din[23:16]),
              sub_byte(din[15:8]),  sub_byte(din[7:0])};
   end

endmodule

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-expansion round: rk = K0 ^ T'(K1^K2^K3^CK).
module sm4_key_round (
   input  logic [31:0] k0,
   input  logic [31:0] k1,
   input  logic [31:0] k2,
   input  logic [31:0] k3,
   input  logic [31:0] ck,
   output logic [31:0] rk
);

   logic [31:0] mix;
   logic [31:0] sub;

   // Fold the three newest key words with the round constant.
   always_comb begin
      mix = k1 ^ k2 ^ k3 ^ ck;
   end

   sbox_32b u_sbox (
      .din  (mix),
      .dout (sub)
   );

   // Key-schedule linear layer L'(b) = b ^ (b<<<13) ^ (b<<<23), then XOR K0.
   always_comb begin
      rk = k0 ^ sub ^ {sub[18:0], sub[31:19]} ^ {sub[8:0], sub[31:9]};
   end

endmodule

// File: rtl/sm4_key_sched.sv
// Restartable SM4 key scheduler: accepts a master key, generates one round
// key per cycle into a register file, and serves them via a registered read port.
module sm4_key_sched
   import sm4_pkg::*;
#(
   parameter int ROUNDS = SM4_ROUNDS,
   parameter int AW     = $clog2(ROUNDS)
) (
   input  logic           CLK_i,
   input  logic           RST_i,
   input  logic [127:0]   MK_i,
   input  logic           MK_VALID_i,
   output logic           MK_READY_o,
   output logic           BUSY_o,
   output logic           KEYS_VALID_o,
   input  logic [AW-1:0]  RK_RADDR_i,
   output logic [31:0]    RK_RDATA_o
);

   sched_state_t state_q;
   sched_state_t state_d;

   logic [AW-1:0] cnt_q;
   logic [31:0]   k0_q;
   logic [31:0]   k1_q;
   logic [31:0]   k2_q;
   logic [31:0]   k3_q;
   logic [31:0]   ck_cur;
   logic [31:0]   rk_new;
   logic [31:0]   rd_q;
   logic [31:0]   rf [ROUNDS];
   logic          accept;
   logic          expanding;
   logic          last_round;

   // Round constant for the key currently being generated.
   always_comb begin
      ck_cur = CK_TBL[cnt_q];
   end

   sm4_key_round u_round (
      .k0 (k0_q),
      .k1 (k1_q),
      .k2 (k2_q),
      .k3 (k3_q),
      .ck (ck_cur),
      .rk (rk_new)
   );

   // Handshake and status levels derived from the current state only.
   always_comb begin
      MK_READY_o   = 1'b1;
      BUSY_o       = 1'b0;
      KEYS_VALID_o = 1'b0;
      unique case (state_q)
         EXPAND: begin
            MK_READY_o = 1'b0;
            BUSY_o     = 1'b1;
         end
         DONE:    KEYS_VALID_o = 1'b1;
         default: ;
      endcase
   end

   // Accept and final-round qualifiers shared by the FSM and datapath.
   always_comb begin
      accept     = MK_VALID_i && MK_READY_o;
      expanding  = (state_q == EXPAND);
      last_round = expanding && (cnt_q == AW'(ROUNDS - 1));
   end

   // Next state: a key in IDLE or DONE starts expansion; the last round finishes it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = EXPAND;
         EXPAND:  if (last_round) state_d = DONE;
         DONE:    if (accept) state_d = EXPAND;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Load the whitened master key on accept, then shift in each new round key.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         cnt_q <= '0;
         k0_q  <= '0;
         k1_q  <= '0;
         k2_q  <= '0;
         k3_q  <= '0;
      end else if (accept) begin
         cnt_q <= '0;
         k0_q  <= MK_i[127:96] ^ FK0;
         k1_q  <= MK_i[95:64]  ^ FK1;
         k2_q  <= MK_i[63:32]  ^ FK2;
         k3_q  <= MK_i[31:0]   ^ FK3;
      end else if (expanding) begin
         cnt_q <= cnt_q + AW'(1);
         k0_q  <= k1_q;
         k1_q  <= k2_q;
         k2_q  <= k3_q;
         k3_q  <= rk_new;
      end
   end

   // Round-key storage; contents are only meaningful once KEYS_VALID_o is high.
   always_ff @(posedge CLK_i) begin
      if (expanding) rf[cnt_q] <= rk_new;
   end

   // Registered read port; a same-edge write to the read index returns the old key.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) rd_q <= '0;
      else       rd_q <= rf[RK_RADDR_i];
   end

   assign RK_RDATA_o = rd_q;

endmodule
